serial_subtractor: RTL and testbench

- Multi-cycle, digit-serial subtractor with borrow; the inverse operation of the team's ripple adder-with-carry blocks.
- Computes D = A − B − Bi over an (N+1)-bit unsigned datapath, K bits per clock, LSB digit first.
- Sits beside the adders in the arithmetic library and uses the same width convention ([N:0] operands).
- Uses a start/busy/done handshake so a controller can trade area for latency.

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bi over N+1 bits, K bits per clock, LSB digit first.
// Start/busy/done handshake; D and Bo only update on completion.
module serial_subtractor #(
    parameter int N = 19,
    parameter int K = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [N:0] A,
    input  logic [N:0] B,
    input  logic       Bi,
    output logic       busy,
    output logic       done,
    output logic [N:0] D,
    output logic       Bo
);

    localparam int NDIG = (N + 1) / K;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N:0]    a_reg;
    logic [N:0]    b_reg;
    logic [N:0]    part;
    logic [N:0]    a_next;
    logic [N:0]    b_next;
    logic [N:0]    part_next;
    logic [N:0]    d_next;
    logic          borrow;
    logic          borrow_next;
    logic          bo_next;
    logic          busy_next;
    logic          done_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [K-1:0]  a_dig;
    logic [K-1:0]  b_dig;
    logic [K:0]    diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            part   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bo     <= 1'b0;
        end else begin
            state  <= state_next;
            a_reg  <= a_next;
            b_reg  <= b_next;
            part   <= part_next;
            borrow <= borrow_next;
            cnt    <= cnt_next;
            busy   <= busy_next;
            done   <= done_next;
            D      <= d_next;
            Bo     <= bo_next;
        end
    end

    always_comb begin
        state_next  = state;
        a_next      = a_reg;
        b_next      = b_reg;
        part_next   = part;
        borrow_next = borrow;
        cnt_next    = cnt;
        d_next      = D;
        bo_next     = Bo;

        a_dig = a_reg[int'(cnt) * K +: K];
        b_dig = b_reg[int'(cnt) * K +: K];
        // K+1-bit difference: the top bit is the borrow into the next digit
        diff  = {1'b0, a_dig} - {1'b0, b_dig} - {{K{1'b0}}, borrow};

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_next      = A;
                    b_next      = B;
                    borrow_next = Bi;
                    cnt_next    = '0;
                    part_next   = '0;
                    state_next  = S_RUN;
                end else if (state == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                part_next[int'(cnt) * K +: K] = diff[K-1:0];
                borrow_next = diff[K];
                cnt_next    = cnt + CW'(1);
                if (cnt == CW'(NDIG - 1)) begin
                    state_next = S_DONE;
                    d_next     = part_next;
                    bo_next    = diff[K];
                end
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next == S_RUN);
        done_next = (state_next == S_DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random vectors,
// with expected {Bo, D} values queued at launch and popped on each done strobe.
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] A;
    logic [19:0] B;
    logic        Bi;
    logic        busy;
    logic        done;
    logic [19:0] D;
    logic        Bo;

    logic [20:0] sb[$];
    int          checks;
    int          fails;

    serial_subtractor #(.N(19), .K(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Bi   (Bi),
        .busy (busy),
        .done (done),
        .D    (D),
        .Bo   (Bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Full-width reference: borrow is bit 20 of the 21-bit difference
    function automatic logic [20:0] model(input logic [19:0] a, input logic [19:0] b, input logic bi);
        logic [20:0] t;
        t = {1'b0, a} - {1'b0, b} - {20'b0, bi};
        return t;
    endfunction

    // Drives a one-cycle start pulse; returns at the negedge after the accepting edge
    task automatic launch(input logic [19:0] a, input logic [19:0] b, input logic bi,
                          input logic [20:0] exp, input bit push);
        @(negedge clk);
        A = a; B = b; Bi = bi; start = 1'b1;
        if (push) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 20) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; A = 20'hFFFFF; B = 20'h00001; Bi = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, Bo, D} !== 23'h0) begin
            fails++;
            $display("[TB] FAIL reset_state: busy=%b done=%b Bo=%b D=%h, want all zero", busy, done, Bo, D);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        bit seen;
        logic [20:0] exp;
        launch(20'h12345, 20'h02345, 1'b0, 21'h010000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || D !== 20'h0) begin
                fails++;
                $display("[TB] FAIL basic_busy_%0d: busy=%b done=%b D=%h, want 1 0 00000", i, busy, done, D);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_done_latency: done=%b busy=%b, want 1 0", done, busy);
        end
        seen = (done === 1'b1);
        if (seen) begin
            exp = sb.pop_front();
            checks++;
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL basic_result: got %h, want %h", {Bo, D}, exp);
            end
        end else if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {Bo, D} !== 21'h010000) begin
            fails++;
            $display("[TB] FAIL basic_done_one_cycle: done=%b {Bo,D}=%h, want 0 010000", done, {Bo, D});
        end
    endtask

    // Directed single operation with a constant expected result
    task automatic test_single(input string name, input logic [19:0] a, input logic [19:0] b,
                               input logic bi, input logic [20:0] exp_const);
        bit seen;
        int cyc;
        logic [20:0] exp;
        launch(a, b, bi, exp_const, 1'b1);
        wait_done(seen, cyc);
        checks++;
        if (!seen || sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s_timeout: done seen=%0d queue=%0d, want done", name, seen, sb.size());
        end else begin
            exp = sb.pop_front();
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL %s: got %h, want %h", name, {Bo, D}, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        bit seen;
        int cyc;
        int extra;
        logic [20:0] exp;
        launch(20'h00010, 20'h00001, 1'b0, 21'h00000F, 1'b1);
        A = 20'hABCDE; B = 20'h12345; Bi = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, cyc);
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL ignore_start_timeout: no done, want done");
        end else begin
            exp = sb.pop_front();
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL ignore_start_result: got %h, want %h", {Bo, D}, exp);
            end
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            fails++;
            $display("[TB] FAIL ignore_start_no_second_op: active cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int cyc;
        logic [20:0] exp;
        launch(20'h00100, 20'h00001, 1'b0, 21'h0000FF, 1'b1);
        wait_done(seen, cyc);
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL b2b_first_timeout: no done, want done");
        end else begin
            exp = sb.pop_front();
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL b2b_first_result: got %h, want %h", {Bo, D}, exp);
            end
        end
        A = 20'h00003; B = 20'h00007; Bi = 1'b1; start = 1'b1;
        sb.push_back(21'h1FFFFB);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_no_idle_gap: busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(seen, cyc);
        checks++;
        if (!seen || cyc != 5) begin
            fails++;
            $display("[TB] FAIL b2b_second_latency: seen=%0d cycles=%0d, want 1 5", seen, cyc);
        end
        if (seen) begin
            exp = sb.pop_front();
            checks++;
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL b2b_second_result: got %h, want %h", {Bo, D}, exp);
            end
        end else if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_reset_abort;
        bit seen;
        int cyc;
        int pulses;
        logic [20:0] exp;
        launch(20'h12345, 20'h00001, 1'b0, 21'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, Bo, D} !== 23'h0) begin
            fails++;
            $display("[TB] FAIL abort_outputs: busy=%b done=%b Bo=%b D=%h, want all zero", busy, done, Bo, D);
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("[TB] FAIL abort_no_done: active cycles=%0d, want 0", pulses);
        end
        launch(20'h00005, 20'h00003, 1'b0, 21'h000002, 1'b1);
        wait_done(seen, cyc);
        checks++;
        if (!seen || cyc != 5) begin
            fails++;
            $display("[TB] FAIL abort_recover_latency: seen=%0d cycles=%0d, want 1 5", seen, cyc);
        end
        if (seen) begin
            exp = sb.pop_front();
            checks++;
            if ({Bo, D} !== exp) begin
                fails++;
                $display("[TB] FAIL abort_recover_result: got %h, want %h", {Bo, D}, exp);
            end
        end else if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_random;
        bit seen;
        int cyc;
        int bad;
        logic [19:0] a;
        logic [19:0] b;
        logic bi;
        logic [20:0] exp;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 20'($urandom);
            b = 20'($urandom);
            bi = 1'($urandom_range(0, 1));
            launch(a, b, bi, model(a, b, bi), 1'b1);
            wait_done(seen, cyc);
            checks++;
            if (!seen) begin
                fails++;
                $display("[TB] FAIL random_%0d_timeout: no done, want done", i);
                if (sb.size() > 0) void'(sb.pop_front());
            end else begin
                exp = sb.pop_front();
                if ({Bo, D} !== exp) begin
                    fails++;
                    if (bad < 10)
                        $display("[TB] FAIL random_%0d: A=%h B=%h Bi=%b got %h, want %h", i, a, b, bi, {Bo, D}, exp);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
        test_reset();
        test_basic();
        test_single("underflow", 20'h00000, 20'h00001, 1'b0, 21'h1FFFFF);
        test_single("full_ripple", 20'h10000, 20'h0FFFF, 1'b1, 21'h000000);
        test_single("max_bi1", 20'hFFFFF, 20'hFFFFF, 1'b1, 21'h1FFFFF);
        test_single("max_bi0", 20'hFFFFF, 20'hFFFFF, 1'b0, 21'h000000);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
